// File: rtl/lpf_cap_bank_seq.sv
// ----------------------------------------------------------------------------
// lpf_cap_bank_seq
//
// Programs the six trimmed capacitor banks of the 3-stage (6th-order) active
// lowpass filter. Each stage has a feedback cap on the op-amp output node and
// a shunt cap from the non-inverting input to ground. A configuration word is
// accepted over valid/ready. The filter output is muted, each code is written
// over a req/ack bank bus, and the sequencer waits for op-amp and RC
// transients to settle. It then unmutes the output and flags the filter valid.
//
// Optional feature (macro LPF_SEQ_SKIP_UNCHANGED_EN):
//   When the macro is defined, any index whose new code matches its valid
//   shadow entry is skipped. If all six codes match, mute/valid are left
//   alone and done pulses in the cycle after the accept. When the macro is
//   undefined, all six indices are always written and no shadow is kept.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   cfg_valid   in   configuration offered
//   cfg_ready   out  idle and able to accept
//   cfg_codes   in   6 codes; code i at [i*CODE_W +: CODE_W]
//                    (0 s0 fb, 1 s0 shunt, 2 s1 fb, 3 s1 shunt, 4 s2 fb, 5 s2 shunt)
//   bank_req    out  write request to trim bus
//   bank_addr   out  cap index 0..5 being written
//   bank_code   out  trim code being written
//   bank_ack    in   bank has latched the code
//   filt_mute   out  forces filter output mute switch closed
//   filt_valid  out  filter configured and settled
//   done        out  one-cycle completion pulse
//   err         out  sticky ack-timeout flag (cleared on next accept)
// ----------------------------------------------------------------------------
module lpf_cap_bank_seq #(
    parameter int CODE_W        = 8,
    parameter int SETTLE_CYCLES = 256,
    parameter int ACK_TIMEOUT   = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [6*CODE_W-1:0] cfg_codes,
    output logic                bank_req,
    output logic [2:0]          bank_addr,
    output logic [CODE_W-1:0]   bank_code,
    input  logic                bank_ack,
    output logic                filt_mute,
    output logic                filt_valid,
    output logic                done,
    output logic                err
);

    localparam int NCAP = 6;
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t                 state;
    logic [6*CODE_W-1:0]    code_q;
    logic [TO_W-1:0]        to_cnt;
    logic [ST_W-1:0]        st_cnt;
    logic [NCAP-1:0]        need_wr;   // index i must be written
    logic [3:0]             first_wr;  // first index to write on accept (6 = none)
    logic [3:0]             next_wr;   // next index to write after bank_addr (6 = none)
    logic                   ack_timeout;

    // Lowest index >= start that needs a write; 6 when there is none.
    function automatic logic [3:0] find_write(input logic [NCAP-1:0] need,
                                              input logic [3:0]      start);
        logic [3:0] r;
        r = 4'd6;
        for (int i = NCAP - 1; i >= 0; i--) begin
            if (4'(i) >= start && need[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic [CODE_W-1:0] code_at(input logic [6*CODE_W-1:0] codes,
                                                  input logic [2:0]          i);
        return codes[i*CODE_W +: CODE_W];
    endfunction

    assign first_wr    = find_write(need_wr, 4'd0);
    assign next_wr     = find_write(need_wr, {1'b0, bank_addr} + 4'd1);
    assign ack_timeout = (state == S_WRITE) && !bank_ack
                         && (to_cnt == TO_W'(ACK_TIMEOUT - 1));

`ifdef LPF_SEQ_SKIP_UNCHANGED_EN
    // Shadow of the code each bank currently holds, valid only after an ack.
    logic [CODE_W-1:0]   shadow [NCAP];
    logic [NCAP-1:0]     shadow_vld;
    logic [6*CODE_W-1:0] cmp_codes;

    // NOTE: this small array is reset explicitly because the skip decision
    // reads it; large memories are usually left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCAP; i++) shadow[i] <= '0;
            shadow_vld <= '0;
        end else if (state == S_WRITE && bank_ack) begin
            shadow[bank_addr]     <= bank_code;
            shadow_vld[bank_addr] <= 1'b1;
        end else if (ack_timeout) begin
            // A bank may hold anything after a failed write; trust nothing.
            shadow_vld <= '0;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        need_wr   = '1;
        cmp_codes = (state == S_IDLE) ? cfg_codes : code_q;
        for (int i = 0; i < NCAP; i++) begin
            need_wr[i] = !(shadow_vld[i] && shadow[i] == cmp_codes[i*CODE_W +: CODE_W]);
        end
    end
`else
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        need_wr = '1;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            code_q     <= '0;
            to_cnt     <= '0;
            st_cnt     <= '0;
            cfg_ready  <= 1'b1;
            bank_req   <= 1'b0;
            bank_addr  <= '0;
            bank_code  <= '0;
            filt_mute  <= 1'b1;
            filt_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        code_q    <= cfg_codes;
                        err       <= 1'b0;
                        cfg_ready <= 1'b0;
                        to_cnt    <= '0;
                        if (first_wr == 4'd6) begin
                            // Nothing changed: complete without touching mute/valid.
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            filt_mute  <= 1'b1;
                            filt_valid <= 1'b0;
                            bank_req   <= 1'b1;
                            bank_addr  <= first_wr[2:0];
                            bank_code  <= code_at(cfg_codes, first_wr[2:0]);
                            state      <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    if (bank_ack) begin
                        bank_req <= 1'b0;
                        to_cnt   <= '0;
                        if (next_wr == 4'd6) begin
                            // The idle cycle after the last write is the
                            // first settle cycle.
                            st_cnt <= ST_W'(SETTLE_CYCLES - 1);
                            state  <= S_SETTLE;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (ack_timeout) begin
                        bank_req   <= 1'b0;
                        to_cnt     <= '0;
                        err        <= 1'b1;
                        filt_mute  <= 1'b1;
                        filt_valid <= 1'b0;
                        cfg_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    bank_req  <= 1'b1;
                    bank_addr <= next_wr[2:0];
                    bank_code <= code_at(code_q, next_wr[2:0]);
                    state     <= S_WRITE;
                end

                S_SETTLE: begin
                    if (st_cnt == '0) begin
                        done       <= 1'b1;
                        filt_valid <= 1'b1;
                        filt_mute  <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        st_cnt <= st_cnt - 1'b1;
                    end
                end

                S_DONE: begin
                    cfg_ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    cfg_ready <= 1'b1;
                    bank_req  <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpf_cap_bank_seq.sv
// ----------------------------------------------------------------------------
// tb_lpf_cap_bank_seq
//
// Directed bench for lpf_cap_bank_seq with SETTLE_CYCLES=4 and ACK_TIMEOUT=15.
// Cycle k is the clock period ending at edge k; the accept happens at edge 0.
// Outputs are sampled on the falling edge in the middle of each cycle.
// The skip-unchanged scenario is compiled only when LPF_SEQ_SKIP_UNCHANGED_EN
// is defined.
// ----------------------------------------------------------------------------
module tb_lpf_cap_bank_seq;

    localparam int CODE_W = 8;

    logic                clk;
    logic                rst_n;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [6*CODE_W-1:0] cfg_codes;
    logic                bank_req;
    logic [2:0]          bank_addr;
    logic [CODE_W-1:0]   bank_code;
    logic                bank_ack;
    logic                filt_mute;
    logic                filt_valid;
    logic                done;
    logic                err;

    lpf_cap_bank_seq #(
        .CODE_W        (CODE_W),
        .SETTLE_CYCLES (4),
        .ACK_TIMEOUT   (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_codes  (cfg_codes),
        .bank_req   (bank_req),
        .bank_addr  (bank_addr),
        .bank_code  (bank_code),
        .bank_ack   (bank_ack),
        .filt_mute  (filt_mute),
        .filt_valid (filt_valid),
        .done       (done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bank model: ack tied high, or ack after ack_delay extra cycles of req,
    // or never acks a chosen address.
    logic     ack_tied;
    int       ack_delay;
    logic     ack_block;
    logic [2:0] ack_block_addr;

    initial begin
        int age;
        age      = 0;
        bank_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_tied) begin
                age      = 0;
                bank_ack = 1'b1;
            end else if (bank_req && !(ack_block && bank_addr == ack_block_addr)) begin
                age++;
                bank_ack = (age >= ack_delay + 1);
            end else begin
                age      = 0;
                bank_ack = 1'b0;
            end
        end
    end

    int n_cmp;
    int n_err;

    // Per-run observations.
    int          wr_cycle[$];
    logic [2:0]  wr_addr[$];
    logic [7:0]  wr_code[$];
    int          wr_len[$];
    int          done_cycle;
    int          end_cycle;
    logic        stable_ok;
    logic        done_valid;
    logic        done_mute;
    logic        first_mute;
    logic        first_err;
    logic        inj_ready;

    function automatic logic [47:0] mk_codes(input logic [7:0] base, input logic [7:0] step);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r[i*8 +: 8] = base + step * 8'(i);
        return r;
    endfunction

    // Offer one configuration at edge 0 and record bus activity until the
    // sequencer is ready again (or a 400-cycle budget runs out).
    task automatic run_cfg(input logic [47:0] codes, input int inj_cycle,
                           input logic [47:0] inj_codes);
        logic prev_req;
        wr_cycle.delete(); wr_addr.delete(); wr_code.delete(); wr_len.delete();
        done_cycle = -1; end_cycle = -1; stable_ok = 1'b1; inj_ready = 1'bx;
        done_valid = 1'bx; done_mute = 1'bx; prev_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_before_accept: got %b want 1", cfg_ready);
        end
        cfg_codes = codes;
        cfg_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cfg_valid  = 1'b0;
                first_mute = filt_mute;
                first_err  = err;
            end
            if (c == inj_cycle) begin
                cfg_valid = 1'b1;
                cfg_codes = inj_codes;
                inj_ready = cfg_ready;
            end
            if (c == inj_cycle + 1) cfg_valid = 1'b0;
            if (bank_req) begin
                if (!prev_req) begin
                    wr_cycle.push_back(c);
                    wr_addr.push_back(bank_addr);
                    wr_code.push_back(bank_code);
                    wr_len.push_back(1);
                end else begin
                    wr_len[wr_len.size()-1] += 1;
                    if (bank_addr !== wr_addr[wr_addr.size()-1] ||
                        bank_code !== wr_code[wr_code.size()-1]) stable_ok = 1'b0;
                end
            end
            prev_req = bank_req;
            if (done === 1'b1 && done_cycle < 0) begin
                done_cycle = c;
                done_valid = filt_valid;
                done_mute  = filt_mute;
            end
            if (cfg_ready === 1'b1) begin
                end_cycle = c;
                break;
            end
        end
        n_cmp++;
        if (end_cycle < 0) begin
            n_err++;
            $display("FAIL run_budget: sequencer not ready within 400 cycles");
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #23;
        n_cmp++;
        if ({cfg_ready, bank_req, bank_addr, bank_code, filt_mute, filt_valid, done, err}
            !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: ready=%b req=%b addr=%0d code=%0h mute=%b valid=%b done=%b err=%b",
                     cfg_ready, bank_req, bank_addr, bank_code, filt_mute, filt_valid, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cfg_ready, bank_req, filt_mute, filt_valid, done}
            !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL idle_after_reset: ready=%b req=%b mute=%b valid=%b done=%b",
                     cfg_ready, bank_req, filt_mute, filt_valid, done);
        end
    endtask

    task automatic test_tied_ack;
        ack_tied = 1'b1;
        run_cfg(mk_codes(8'h11, 8'h11), -10, '0);
        n_cmp++;
        if (wr_cycle.size() !== 6) begin
            n_err++;
            $display("FAIL tied_write_count: got %0d want 6", wr_cycle.size());
        end
        for (int i = 0; i < 6 && i < wr_cycle.size(); i++) begin
            n_cmp++;
            if (wr_cycle[i] !== 1 + 2*i || wr_addr[i] !== 3'(i) ||
                wr_code[i] !== 8'h11 * 8'(i + 1) || wr_len[i] !== 1) begin
                n_err++;
                $display("FAIL tied_write%0d: got cyc=%0d addr=%0d code=%0h len=%0d want cyc=%0d addr=%0d code=%0h len=1",
                         i, wr_cycle[i], wr_addr[i], wr_code[i], wr_len[i], 1 + 2*i, i, 8'h11 * 8'(i + 1));
            end
        end
        n_cmp++;
        if (done_cycle !== 16 || end_cycle !== 17) begin
            n_err++;
            $display("FAIL tied_done_cycle: got done=%0d ready=%0d want done=16 ready=17",
                     done_cycle, end_cycle);
        end
        n_cmp++;
        if (first_mute !== 1'b1 || done_valid !== 1'b1 || done_mute !== 1'b0 ||
            filt_valid !== 1'b1 || filt_mute !== 1'b0) begin
            n_err++;
            $display("FAIL tied_mute_valid: got first_mute=%b done_valid=%b done_mute=%b valid=%b mute=%b want 1 1 0 1 0",
                     first_mute, done_valid, done_mute, filt_valid, filt_mute);
        end
    endtask

    task automatic test_ack_delay;
        ack_tied  = 1'b0;
        ack_delay = 3;
        run_cfg(mk_codes(8'hA0, 8'h01), -10, '0);
        n_cmp++;
        if (wr_cycle.size() !== 6 || stable_ok !== 1'b1) begin
            n_err++;
            $display("FAIL delay_count_stable: got %0d writes stable=%b want 6 stable=1",
                     wr_cycle.size(), stable_ok);
        end
        for (int i = 0; i < 6 && i < wr_cycle.size(); i++) begin
            n_cmp++;
            if (wr_cycle[i] !== 1 + 5*i || wr_addr[i] !== 3'(i) ||
                wr_code[i] !== 8'hA0 + 8'(i) || wr_len[i] !== 4) begin
                n_err++;
                $display("FAIL delay_write%0d: got cyc=%0d addr=%0d code=%0h len=%0d want cyc=%0d addr=%0d code=%0h len=4",
                         i, wr_cycle[i], wr_addr[i], wr_code[i], wr_len[i], 1 + 5*i, i, 8'hA0 + 8'(i));
            end
        end
        n_cmp++;
        if (done_cycle !== 34) begin
            n_err++;
            $display("FAIL delay_done_cycle: got %0d want 34", done_cycle);
        end
    endtask

    task automatic test_timeout;
        ack_tied       = 1'b0;
        ack_delay      = 0;
        ack_block      = 1'b1;
        ack_block_addr = 3'd2;
        run_cfg(mk_codes(8'h31, 8'h01), -10, '0);
        ack_block = 1'b0;
        n_cmp++;
        if (wr_cycle.size() !== 3) begin
            n_err++;
            $display("FAIL timeout_write_count: got %0d want 3", wr_cycle.size());
        end else begin
            n_cmp++;
            if (wr_cycle[2] !== 5 || wr_addr[2] !== 3'd2 || wr_code[2] !== 8'h33 || wr_len[2] !== 15) begin
                n_err++;
                $display("FAIL timeout_req_len: got cyc=%0d addr=%0d code=%0h len=%0d want cyc=5 addr=2 code=33 len=15",
                         wr_cycle[2], wr_addr[2], wr_code[2], wr_len[2]);
            end
        end
        n_cmp++;
        if (end_cycle !== 20 || done_cycle !== -1) begin
            n_err++;
            $display("FAIL timeout_end: got ready_cycle=%0d done_cycle=%0d want 20 and -1",
                     end_cycle, done_cycle);
        end
        n_cmp++;
        if ({err, filt_mute, filt_valid, bank_req, cfg_ready} !== 5'b11001) begin
            n_err++;
            $display("FAIL timeout_flags: got err=%b mute=%b valid=%b req=%b ready=%b want 1 1 0 0 1",
                     err, filt_mute, filt_valid, bank_req, cfg_ready);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_sticky: got err=%b done=%b want err=1 done=0", err, done);
        end
    endtask

    task automatic test_busy_ignore;
        ack_tied = 1'b1;
        run_cfg(mk_codes(8'h51, 8'h01), 13, mk_codes(8'hE0, 8'h02));
        n_cmp++;
        if (first_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_cleared_on_accept: got %b want 0", first_err);
        end
        n_cmp++;
        if (inj_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_in_settle: got %b want 0", inj_ready);
        end
        n_cmp++;
        if (wr_cycle.size() !== 6 || done_cycle !== 16 || end_cycle !== 17) begin
            n_err++;
            $display("FAIL busy_ignore_timing: got writes=%0d done=%0d ready=%0d want 6 16 17",
                     wr_cycle.size(), done_cycle, end_cycle);
        end
        for (int i = 0; i < 6 && i < wr_code.size(); i++) begin
            n_cmp++;
            if (wr_code[i] !== 8'h51 + 8'(i)) begin
                n_err++;
                $display("FAIL busy_ignore_code%0d: got %0h want %0h", i, wr_code[i], 8'h51 + 8'(i));
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bank_req !== 1'b0 || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL busy_ignore_no_restart: got req=%b ready=%b want 0 1", bank_req, cfg_ready);
        end
    endtask

    task automatic test_reset_mid;
        ack_tied = 1'b1;
        @(negedge clk);
        cfg_codes = mk_codes(8'h71, 8'h01);
        cfg_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) cfg_valid = 1'b0;
        end
        n_cmp++;
        if (bank_req !== 1'b1 || bank_addr !== 3'd2 || bank_code !== 8'h73) begin
            n_err++;
            $display("FAIL third_write_active: got req=%b addr=%0d code=%0h want 1 2 73",
                     bank_req, bank_addr, bank_code);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cfg_ready, bank_req, bank_addr, bank_code, filt_mute, filt_valid, done, err}
            !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset_mid: ready=%b req=%b addr=%0d code=%0h mute=%b valid=%b done=%b err=%b",
                     cfg_ready, bank_req, bank_addr, bank_code, filt_mute, filt_valid, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cfg(mk_codes(8'h81, 8'h01), -10, '0);
        n_cmp++;
        if (wr_cycle.size() !== 6 || done_cycle !== 16) begin
            n_err++;
            $display("FAIL post_reset_run: got writes=%0d done=%0d want 6 16",
                     wr_cycle.size(), done_cycle);
        end
        for (int i = 0; i < 6 && i < wr_addr.size(); i++) begin
            n_cmp++;
            if (wr_addr[i] !== 3'(i) || wr_code[i] !== 8'h81 + 8'(i)) begin
                n_err++;
                $display("FAIL post_reset_write%0d: got addr=%0d code=%0h want addr=%0d code=%0h",
                         i, wr_addr[i], wr_code[i], i, 8'h81 + 8'(i));
            end
        end
    endtask

`ifdef LPF_SEQ_SKIP_UNCHANGED_EN
    task automatic test_skip_unchanged;
        logic [47:0] codes;
        ack_tied = 1'b1;
        run_cfg(mk_codes(8'h81, 8'h01), -10, '0);
        n_cmp++;
        if (wr_cycle.size() !== 0 || done_cycle !== 1 || end_cycle !== 2) begin
            n_err++;
            $display("FAIL skip_all: got writes=%0d done=%0d ready=%0d want 0 1 2",
                     wr_cycle.size(), done_cycle, end_cycle);
        end
        n_cmp++;
        if (first_mute !== 1'b0 || done_valid !== 1'b1 || filt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL skip_all_undisturbed: got mute=%b done_valid=%b valid=%b want 0 1 1",
                     first_mute, done_valid, filt_valid);
        end
        codes = mk_codes(8'h81, 8'h01);
        codes[3*8 +: 8] = 8'hC4;
        run_cfg(codes, -10, '0);
        n_cmp++;
        if (wr_cycle.size() !== 1) begin
            n_err++;
            $display("FAIL skip_one_count: got %0d want 1", wr_cycle.size());
        end else begin
            n_cmp++;
            if (wr_cycle[0] !== 1 || wr_addr[0] !== 3'd3 || wr_code[0] !== 8'hC4) begin
                n_err++;
                $display("FAIL skip_one_write: got cyc=%0d addr=%0d code=%0h want 1 3 c4",
                         wr_cycle[0], wr_addr[0], wr_code[0]);
            end
        end
        n_cmp++;
        if (done_cycle !== 6 || filt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL skip_one_done: got done=%0d valid=%b want 6 1", done_cycle, filt_valid);
        end
    endtask
`endif

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        cfg_valid      = 1'b0;
        cfg_codes      = '0;
        ack_tied       = 1'b1;
        ack_delay      = 0;
        ack_block      = 1'b0;
        ack_block_addr = 3'd0;

        test_reset;
        test_tied_ack;
        test_ack_delay;
        test_timeout;
        test_busy_ignore;
        test_reset_mid;
`ifdef LPF_SEQ_SKIP_UNCHANGED_EN
        test_skip_unchanged;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
